// File: rtl/vme_arb_pkg.sv
// Shared types and constants for the VME register-bank arbiter.
// Optional timeout logic in the top is enabled by VME_ARB_TIMEOUT_EN.
package vme_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } mst_t;

    localparam int MAX_DATA_W = 64;
    localparam logic [MAX_DATA_W-1:0] ERR_RDATA = '1;

endpackage

// File: rtl/vme_bus_arbiter_rr_arb2.sv
// Two-way round-robin grant: combinational pick, pointer updated on en.
// The pointer resets to M1 so M0 wins the first contended round.
module rr_arb2
    import vme_arb_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic [1:0] req,
    input  logic       en,
    input  mst_t       win,
    output mst_t       grant
);

    mst_t last;

    always_comb begin
        grant = M0;
        if (req[0] && req[1]) begin
            grant = (last == M0) ? M1 : M0;
        end else if (req[1]) begin
            grant = M1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            last <= M1;
        end else if (en) begin
            last <= win;
        end
    end

endmodule

// File: rtl/vme_bus_arbiter.sv
// Two-master arbiter in front of a strobe/done VME register-bank slave.
// Define VME_ARB_TIMEOUT_EN to add the WAIT timeout and error response.
module vme_bus_arbiter
    import vme_arb_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic [ADDR_W-1:0] VMEAddr,
    output logic [DATA_W-1:0] VMEWrData,
    output logic              VMERdMem,
    output logic              VMEWrMem,
    input  logic [DATA_W-1:0] VMERdData,
    input  logic              VMERdDone,
    input  logic              VMEWrDone
);

    state_t state;
    state_t nxt;
    mst_t owner;
    mst_t grant;

    logic we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] rdata0_r;
    logic [DATA_W-1:0] rdata1_r;
    logic [DATA_W-1:0] rsp_data;

    logic done_hit;
    logic tmo_hit;
    logic tmo_fire;
    logic start;
    logic finish;

    // Only the done that matches the outstanding direction counts.
    assign done_hit = we_r ? VMEWrDone : VMERdDone;

    rr_arb2 u_arb (
        .Clk   (Clk),
        .Rst   (Rst),
        .req   ({m1_req, m0_req}),
        .en    (state == RESP),
        .win   (owner),
        .grant (grant)
    );

    always_comb begin
        nxt      = state;
        tmo_fire = 1'b0;
        unique case (state)
            IDLE: begin
                if (m0_req || m1_req) nxt = STROBE;
            end
            STROBE: begin
                nxt = done_hit ? RESP : WAIT;
            end
            WAIT: begin
                if (done_hit) begin
                    nxt = RESP;
                end else if (tmo_hit) begin
                    nxt      = RESP;
                    tmo_fire = 1'b1;
                end
            end
            RESP: begin
                nxt = IDLE;
            end
            default: begin
                nxt = IDLE;
            end
        endcase
    end

    assign start    = (state == IDLE) && (nxt == STROBE);
    assign finish   = (state != RESP) && (nxt == RESP);
    assign rsp_data = tmo_fire ? ERR_RDATA[DATA_W-1:0] : VMERdData;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            owner    <= M0;
            we_r     <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= '0;
            rdata0_r <= '0;
            rdata1_r <= '0;
        end else begin
            state <= nxt;
            if (start) begin
                owner   <= grant;
                we_r    <= (grant == M1) ? m1_we    : m0_we;
                addr_r  <= (grant == M1) ? m1_addr  : m0_addr;
                wdata_r <= (grant == M1) ? m1_wdata : m0_wdata;
            end
            if (finish && !we_r && owner == M0) rdata0_r <= rsp_data;
            if (finish && !we_r && owner == M1) rdata1_r <= rsp_data;
        end
    end

    assign VMEAddr   = addr_r;
    assign VMEWrData = wdata_r;
    assign VMERdMem  = (state == STROBE) && !we_r;
    assign VMEWrMem  = (state == STROBE) && we_r;
    assign m0_ack    = (state == RESP) && (owner == M0);
    assign m1_ack    = (state == RESP) && (owner == M1);
    assign m0_rdata  = rdata0_r;
    assign m1_rdata  = rdata1_r;

`ifdef VME_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic err_r;

    // tmo_cnt equals the number of WAIT cycles already spent.
    assign tmo_hit = (tmo_cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            tmo_cnt <= '0;
            err_r   <= 1'b0;
        end else begin
            if (start) begin
                tmo_cnt <= '0;
            end else if (state == WAIT) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
            if (finish) err_r <= tmo_fire;
        end
    end

    assign m0_err = m0_ack && err_r;
    assign m1_err = m1_ack && err_r;
`else
    logic unused_cfg;

    assign unused_cfg = |TIMEOUT;
    assign tmo_hit    = 1'b0;
    assign m0_err     = 1'b0;
    assign m1_err     = 1'b0;
`endif

endmodule

// File: tb/tb_vme_bus_arbiter.sv
// Directed bench for vme_bus_arbiter; timeout case follows VME_ARB_TIMEOUT_EN.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_vme_bus_arbiter;

    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_ack, m1_ack, m0_err, m1_err;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] VMEAddr;
    logic [DW-1:0] VMEWrData, VMERdData;
    logic          VMERdMem, VMEWrMem, VMERdDone, VMEWrDone;

    int n_chk  = 0;
    int n_fail = 0;

    vme_bus_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TMO)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_ack    (m0_ack),
        .m0_rdata  (m0_rdata),
        .m0_err    (m0_err),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_ack    (m1_ack),
        .m1_rdata  (m1_rdata),
        .m1_err    (m1_err),
        .VMEAddr   (VMEAddr),
        .VMEWrData (VMEWrData),
        .VMERdMem  (VMERdMem),
        .VMEWrMem  (VMEWrMem),
        .VMERdData (VMERdData),
        .VMERdDone (VMERdDone),
        .VMEWrDone (VMEWrDone)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic set_req(input bit m, input bit v, input bit we,
                           input logic [AW-1:0] a, input logic [DW-1:0] wd);
        if (m) begin
            m1_req = v; m1_we = we; m1_addr = a; m1_wdata = wd;
        end else begin
            m0_req = v; m0_we = we; m0_addr = a; m0_wdata = wd;
        end
    endtask

    function automatic logic ack_of(input bit m);
        return m ? m1_ack : m0_ack;
    endfunction

    function automatic logic err_of(input bit m);
        return m ? m1_err : m0_err;
    endfunction

    function automatic logic [DW-1:0] rdata_of(input bit m);
        return m ? m1_rdata : m0_rdata;
    endfunction

    // One transaction against a slave that answers one cycle after the strobe.
    task automatic txn(input bit m, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                       input logic [DW-1:0] exp_rd, input string tag);
        set_req(m, 1'b1, we, a, wd);
        tick();
        check({tag, "_rdmem"}, 32'(VMERdMem), 32'(!we));
        check({tag, "_wrmem"}, 32'(VMEWrMem), 32'(we));
        check({tag, "_addr"}, 32'(VMEAddr), 32'(a));
        if (we) check({tag, "_wrdata"}, VMEWrData, wd);
        tick();
        check({tag, "_strobe_once"}, 32'(VMERdMem | VMEWrMem), 32'd0);
        check({tag, "_ack_early"}, 32'(ack_of(m)), 32'd0);
        if (we) begin
            VMEWrDone = 1'b1;
        end else begin
            VMERdDone = 1'b1;
            VMERdData = rd;
        end
        tick();
        VMEWrDone = 1'b0;
        VMERdDone = 1'b0;
        check({tag, "_ack"}, 32'(ack_of(m)), 32'd1);
        check({tag, "_ack_other"}, 32'(ack_of(!m)), 32'd0);
        check({tag, "_err"}, 32'(err_of(m)), 32'd0);
        check({tag, "_rdata"}, rdata_of(m), exp_rd);
        set_req(m, 1'b0, 1'b0, '0, '0);
        tick();
        check({tag, "_ack_done"}, 32'(ack_of(m)), 32'd0);
        check({tag, "_rdata_hold"}, rdata_of(m), exp_rd);
    endtask

    initial begin
        int strobes;
        int acks;
        int last_st;
        int ack_c;
        int n_ack;
        bit pend;
        bit who;
        bit em;
        logic [DW-1:0] pdata;
        logic [DW-1:0] exp_d [2];

        Rst = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        VMERdData = '0;
        VMERdDone = 1'b0;
        VMEWrDone = 1'b0;
        tick();
        tick();
        check("rst_acks", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
        check("rst_strobes", 32'({VMERdMem, VMEWrMem}), 32'd0);
        check("rst_addr", 32'(VMEAddr), 32'd0);
        check("rst_wrdata", VMEWrData, 32'd0);
        check("rst_rdata", m0_rdata | m1_rdata, 32'd0);
        Rst = 1'b0;
        tick();

        txn(1'b0, 1'b0, 8'h03, 32'h0, 32'h0000_00A5, 32'h0000_00A5, "rd0");
        txn(1'b0, 1'b1, 8'h00, 32'h1234_5678, 32'h0, 32'h0000_00A5, "wr0");

        // Wrong-direction done first, real done three cycles later.
        set_req(1'b0, 1'b1, 1'b0, 8'h05, '0);
        tick();
        check("wd_rdmem", 32'(VMERdMem), 32'd1);
        tick();
        VMEWrDone = 1'b1;
        VMERdData = 32'hDEAD_BEEF;
        tick();
        VMEWrDone = 1'b0;
        check("wd_ignored", 32'(m0_ack), 32'd0);
        tick();
        check("wd_wait", 32'(m0_ack | VMERdMem), 32'd0);
        tick();
        VMERdDone = 1'b1;
        VMERdData = 32'h0000_5A5A;
        check("wd_still_wait", 32'(m0_ack), 32'd0);
        tick();
        VMERdDone = 1'b0;
        check("wd_ack", 32'(m0_ack), 32'd1);
        check("wd_rdata", m0_rdata, 32'h0000_5A5A);
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        tick();

        // Fresh pointer so m0 wins the first contended round.
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check("rst2_rdata", m0_rdata, 32'd0);

        set_req(1'b0, 1'b1, 1'b0, 8'h10, '0);
        set_req(1'b1, 1'b1, 1'b0, 8'h20, '0);
        strobes = 0;
        acks = 0;
        last_st = -1;
        pend = 1'b0;
        pdata = '0;
        exp_d[0] = '0;
        exp_d[1] = '0;
        for (int c = 1; c <= 40 && acks < 4; c++) begin
            tick();
            VMERdDone = 1'b0;
            if (pend) begin
                VMERdDone = 1'b1;
                VMERdData = pdata;
                pend = 1'b0;
            end
            if (VMERdMem || VMEWrMem) begin
                check("arb_no_overlap", 32'(VMERdMem & VMEWrMem), 32'd0);
                em = strobes[0];
                check("arb_addr", 32'(VMEAddr), em ? 32'h20 : 32'h10);
                if (last_st >= 0) check("arb_gap", 32'(c - last_st), 32'd4);
                last_st = c;
                strobes++;
                pdata = 32'hD000_0000 + 32'(strobes);
                exp_d[em] = pdata;
                pend = 1'b1;
            end
            if (m0_ack || m1_ack) begin
                check("arb_one_ack", 32'(m0_ack & m1_ack), 32'd0);
                who = m1_ack;
                check("arb_order", 32'(who), 32'(acks % 2));
                check("arb_rdata", rdata_of(who), exp_d[who]);
                acks++;
                if (acks == 4) begin
                    set_req(1'b0, 1'b0, 1'b0, '0, '0);
                    set_req(1'b1, 1'b0, 1'b0, '0, '0);
                end
            end
        end
        VMERdDone = 1'b0;
        check("arb_strobes", 32'(strobes), 32'd4);
        check("arb_acks", 32'(acks), 32'd4);
        tick();

        // Reset while the slave still owes a done.
        set_req(1'b1, 1'b1, 1'b0, 8'h07, '0);
        tick();
        check("rm_rdmem", 32'(VMERdMem), 32'd1);
        tick();
        Rst = 1'b1;
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        tick();
        Rst = 1'b0;
        check("rm_strobes", 32'({VMERdMem, VMEWrMem}), 32'd0);
        check("rm_ack0", 32'({m0_ack, m1_ack}), 32'd0);
        VMERdDone = 1'b1;
        VMERdData = 32'h0000_0BAD;
        tick();
        VMERdDone = 1'b0;
        check("rm_late_done", 32'({m0_ack, m1_ack, VMERdMem}), 32'd0);
        tick();
        check("rm_idle", 32'({m0_ack, m1_ack, VMERdMem}), 32'd0);
        txn(1'b1, 1'b0, 8'h09, 32'h0, 32'h0000_0099, 32'h0000_0099, "rd1");

        // Slave never answers.
        set_req(1'b0, 1'b1, 1'b0, 8'h11, '0);
        ack_c = -1;
        n_ack = 0;
`ifdef VME_ARB_TIMEOUT_EN
        for (int c = 1; c <= 30 && ack_c < 0; c++) begin
            tick();
            if (m0_ack) begin
                ack_c = c;
                check("tmo_err", 32'(m0_err), 32'd1);
                check("tmo_rdata", m0_rdata, 32'hFFFF_FFFF);
                set_req(1'b0, 1'b0, 1'b0, '0, '0);
            end
        end
        check("tmo_ack_cycle", 32'(ack_c), 32'd10);
        tick();
        VMERdDone = 1'b1;
        VMERdData = 32'h0000_1111;
        tick();
        VMERdDone = 1'b0;
        check("tmo_late_done", 32'({m0_ack, m0_err}), 32'd0);
        tick();
        check("tmo_rdata_hold", m0_rdata, 32'hFFFF_FFFF);
`else
        for (int c = 1; c <= 1000; c++) begin
            tick();
            if (m0_ack) n_ack++;
            if (m0_err) n_ack++;
        end
        check("notmo_no_ack", 32'(n_ack), 32'd0);
        check("notmo_rdata", m0_rdata, 32'd0);
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
`endif
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
